// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encodings and bit-period helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAITHI
  } rx_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int bit_period(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-FF synchroniser, centre-sampling deserialiser, parity/framing checks.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int N         = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_par_err,
  output logic                 o_frm_err
);

  localparam int CNT_W = $clog2(N + 1);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(N / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic [1:0]           r_sync;
  logic                 r_prev;
  rx_state_e            r_st;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_sh;
  logic                 r_par_bit;
  logic                 w_rx_s;
  logic                 w_par_exp;

  assign w_rx_s    = r_sync[1];
  assign w_par_exp = (PARITY == PAR_ODD) ? ~^r_sh : ^r_sh;

  // Synchroniser resets to idle-high so reset release never looks like a start edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync    <= 2'b11;
      r_prev    <= 1'b1;
      r_st      <= RX_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_sh      <= '0;
      r_par_bit <= 1'b0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_par_err <= 1'b0;
      o_frm_err <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_rxd};
      r_prev  <= w_rx_s;
      o_valid <= 1'b0;
      case (r_st)
        RX_IDLE: begin
          if (r_prev && !w_rx_s) begin
            r_st  <= RX_START;
            r_cnt <= HALF;
          end
        end
        RX_START: begin
          if (r_cnt == '0) begin
            if (w_rx_s) begin
              r_st <= RX_IDLE;
            end else begin
              r_st  <= RX_DATA;
              r_cnt <= BIT_LAST;
              r_idx <= '0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == '0) begin
            r_sh  <= {w_rx_s, r_sh[DATA_BITS-1:1]};
            r_cnt <= BIT_LAST;
            if (r_idx == IDX_LAST) begin
              if (PARITY == PAR_NONE) r_st <= RX_STOP;
              else                    r_st <= RX_PARITY;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RX_PARITY: begin
          if (r_cnt == '0) begin
            r_par_bit <= w_rx_s;
            r_st      <= RX_STOP;
            r_cnt     <= BIT_LAST;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == '0) begin
            o_valid   <= 1'b1;
            o_data    <= r_sh;
            o_par_err <= (PARITY != PAR_NONE) && (r_par_bit != w_par_exp);
            o_frm_err <= !w_rx_s;
            r_st      <= w_rx_s ? RX_IDLE : RX_WAITHI;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RX_WAITHI: begin
          if (w_rx_s) r_st <= RX_IDLE;
        end
        default: r_st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_xcvr_param.sv
// Full-duplex UART transceiver: valid/ready serialiser here, deserialiser in uart_rx_core.
module uart_xcvr_param
  import uart_pkg::*;
#(
  parameter int PrSv_ClkFreq_c  = 100000000,
  parameter int PrSv_Baud_c     = 115200,
  parameter int PrSv_DataBits_c = 8,
  parameter int PrSv_Parity_c   = PAR_NONE,
  parameter int PrSv_StopBits_c = 1
) (
  input  logic                       CpSl_Clk_i,
  input  logic                       CpSl_Rst_iN,
  input  logic                       CpSl_RxData_i,
  output logic                       CpSl_TxData_o,
  input  logic [PrSv_DataBits_c-1:0] CpSv_TxData_i,
  input  logic                       CpSl_TxValid_i,
  output logic                       CpSl_TxReady_o,
  output logic [PrSv_DataBits_c-1:0] CpSv_RxData_o,
  output logic                       CpSl_RxValid_o,
  output logic                       CpSl_RxParErr_o,
  output logic                       CpSl_RxFrmErr_o
);

  localparam int N        = bit_period(PrSv_ClkFreq_c, PrSv_Baud_c);
  localparam int STOP_LEN = N * PrSv_StopBits_c;
  localparam int CNT_W    = $clog2(STOP_LEN + 1);
  localparam int IDX_W    = $clog2(PrSv_DataBits_c + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PrSv_DataBits_c - 1);

  generate
    if (N < 4 || PrSv_DataBits_c < 5 || PrSv_DataBits_c > 9) begin : g_bad_cfg
      $error("uart_xcvr_param: bit period below 4 clocks or data width outside 5..9");
    end
  endgenerate

  tx_state_e                  r_tx_st;
  logic [CNT_W-1:0]           r_tx_cnt;
  logic [IDX_W-1:0]           r_tx_idx;
  logic [PrSv_DataBits_c-1:0] r_tx_sh;
  logic                       r_tx_par;
  logic                       r_tx_line;
  logic                       r_tx_rdy;
  logic                       w_tx_par;

  assign w_tx_par       = (PrSv_Parity_c == PAR_ODD) ? ~^CpSv_TxData_i : ^CpSv_TxData_i;
  assign CpSl_TxData_o  = r_tx_line;
  assign CpSl_TxReady_o = r_tx_rdy;

  // Line bit is registered one clock ahead of its period; the counter times each bit.
  always_ff @(posedge CpSl_Clk_i or negedge CpSl_Rst_iN) begin
    if (!CpSl_Rst_iN) begin
      r_tx_st   <= TX_IDLE;
      r_tx_cnt  <= '0;
      r_tx_idx  <= '0;
      r_tx_sh   <= '0;
      r_tx_par  <= 1'b0;
      r_tx_line <= 1'b1;
      r_tx_rdy  <= 1'b0;
    end else begin
      case (r_tx_st)
        TX_IDLE: begin
          r_tx_line <= 1'b1;
          r_tx_rdy  <= 1'b1;
          if (CpSl_TxValid_i && r_tx_rdy) begin
            r_tx_sh   <= CpSv_TxData_i;
            r_tx_par  <= w_tx_par;
            r_tx_line <= 1'b0;
            r_tx_rdy  <= 1'b0;
            r_tx_cnt  <= BIT_LAST;
            r_tx_st   <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_cnt == '0) begin
            r_tx_st   <= TX_DATA;
            r_tx_line <= r_tx_sh[0];
            r_tx_cnt  <= BIT_LAST;
            r_tx_idx  <= '0;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        TX_DATA: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt <= BIT_LAST;
            if (r_tx_idx == IDX_LAST) begin
              if (PrSv_Parity_c == PAR_NONE) begin
                r_tx_st   <= TX_STOP;
                r_tx_line <= 1'b1;
                r_tx_cnt  <= STOP_LAST;
              end else begin
                r_tx_st   <= TX_PARITY;
                r_tx_line <= r_tx_par;
              end
            end else begin
              r_tx_idx  <= r_tx_idx + 1'b1;
              r_tx_sh   <= r_tx_sh >> 1;
              r_tx_line <= r_tx_sh[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        TX_PARITY: begin
          if (r_tx_cnt == '0) begin
            r_tx_st   <= TX_STOP;
            r_tx_line <= 1'b1;
            r_tx_cnt  <= STOP_LAST;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        TX_STOP: begin
          if (r_tx_cnt == '0) begin
            r_tx_st  <= TX_IDLE;
            r_tx_rdy <= 1'b1;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        default: r_tx_st <= TX_IDLE;
      endcase
    end
  end

  uart_rx_core #(
    .N         (N),
    .DATA_BITS (PrSv_DataBits_c),
    .PARITY    (PrSv_Parity_c)
  ) u_rx (
    .i_clk     (CpSl_Clk_i),
    .i_rst_n   (CpSl_Rst_iN),
    .i_rxd     (CpSl_RxData_i),
    .o_data    (CpSv_RxData_o),
    .o_valid   (CpSl_RxValid_o),
    .o_par_err (CpSl_RxParErr_o),
    .o_frm_err (CpSl_RxFrmErr_o)
  );

endmodule

// File: doc/uart_xcvr_param.md
Name: uart_xcvr_param

Overview:
Parametrised full-duplex UART transceiver. It replaces the fixed demo UART pins with a real serial engine.
- TX side: a valid/ready parallel interface feeding the serialiser.
- RX side: an oversampled-at-centre deserialiser with parity and framing error reporting.
- Placement: between the PC serial line (CpSl_RxData_i / CpSl_TxData_o) and internal command/status logic.

Parameters:
- PrSv_ClkFreq_c, 100000000: system clock frequency in Hz.
- PrSv_Baud_c, 115200: line baud rate.
- PrSv_DataBits_c, 8: data bits per frame. Legal values are 5 to 9.
- PrSv_Parity_c, 0: 0 = none, 1 = odd, 2 = even.
- PrSv_StopBits_c, 1: TX stop bits, 1 or 2. RX always checks the first stop bit only.

Ports:
- CpSl_Clk_i  in  1  system clock
- CpSl_Rst_iN  in  1  reset, asynchronous, active-low
- CpSl_RxData_i  in  1  serial input from PC, asynchronous
- CpSl_TxData_o  out  1  serial output to PC
- CpSv_TxData_i  in  DataBits  parallel TX word
- CpSl_TxValid_i  in  1  TX word valid
- CpSl_TxReady_o  out  1  TX can accept a word
- CpSv_RxData_o  out  DataBits  last received word
- CpSl_RxValid_o  out  1  one-cycle pulse, RX word available
- CpSl_RxParErr_o  out  1  parity error, qualified by RxValid
- CpSl_RxFrmErr_o  out  1  stop-bit error, qualified by RxValid

Behaviour:
- Bit period: N = (ClkFreq + Baud/2) / Baud clocks, integer. Elaboration error if N < 4. Example: 100 MHz at 115200 gives N = 868.
- Reset values:
  - CpSl_TxData_o = 1 (line idle high)
  - CpSl_TxReady_o = 0 during reset, 1 on the first clock after reset release
  - CpSv_RxData_o = 0
  - CpSl_RxValid_o = 0
  - Both error flags = 0
  - Both FSMs in IDLE; all counters 0.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if Parity = 0) -> STOP -> IDLE.
  - TxReady is 1 only in IDLE.
  - Handshake occurs when TxValid & TxReady. The word is latched, and TxData_o drives 0 (start bit) on the next clock.
  - Every bit lasts exactly N clocks. Data is sent LSB first.
  - Parity bit:
    - odd: bit = ~^data (odd total count of ones)
    - even: bit = ^data
  - STOP lasts N × StopBits clocks, then the FSM returns to IDLE and TxReady rises.
  - Minimum frame-to-frame period is (1 + DataBits + P + StopBits) × N + 1 clocks, where P = 1 if parity is enabled, else 0.
  - TxValid while busy is ignored; the word must be held until the handshake.
- RX input: CpSl_RxData_i passes through a 2-FF synchroniser. The synchronised value is called rx_s.
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE, with an extra WAITHI state.
  - IDLE: a falling edge on rx_s (1 then 0) enters START and loads the counter to N/2.
  - START: at mid-bit, if rx_s = 1 the event is a glitch; return to IDLE with no output. Otherwise continue.
  - DATA / PARITY: one sample every N clocks at bit centre. Data shifts in LSB first.
  - STOP: sampled at the centre of the stop bit.
    - In the cycle after the stop sample, RxValid pulses for 1 clock. RxData and both error flags update in that same cycle and hold until the next frame.
    - ParErr = received parity differs from the computed parity. ParErr = 0 when parity is disabled.
    - FrmErr = stop sample was 0.
  - After a frame with FrmErr (break or line held low), go to WAITHI. Re-arm to IDLE only after rx_s = 1 is seen.
  - With no error, return to IDLE right after the stop sample. A new start edge is accepted from the second half of the stop bit onward.
- TX and RX are fully independent. Simultaneous activity and loopback (TxData_o tied to RxData_i) are legal.
- Reset mid-frame: both FSMs abort at once and the line returns to 1.
  - No RxValid pulse is produced for the partial frame.
  - A TX word accepted before reset is lost.

Decomposition:
- Shared package uart_pkg holds:
  - the parity-mode constants (PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2)
  - the TX and RX state encodings
  - a constant function for the bit period N.
- One sub-module, uart_rx_core: synchroniser, RX FSM and error logic. The TX FSM stays in the top level.

Test Plan:
All scenarios use ClkFreq = 16, Baud = 1, so N = 16.
- Reset release: TxData_o = 1, TxReady = 1 at cycle 1. Send 0xA5 (8N1) -> line shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 16 clocks. TxReady = 0 for 160 clocks.
- Loopback 8E1, send 0x3C -> RxValid pulses once, RxData = 0x3C, ParErr = 0, FrmErr = 0. Pulse occurs within 1 bit period of the TX stop bit centre.
- Drive an RX frame of 0x55 with the parity bit inverted (8O1) -> RxData = 0x55, ParErr = 1, FrmErr = 0.
- Drive a 6-clock low glitch on RxData_i -> no RxValid, FSM back in IDLE. A following valid 0x81 is received correctly.
- Drive 0x00 with the stop bit = 0, line held low for 40 clocks -> FrmErr = 1, RxValid = 1, and no second frame until the line goes high.
- Assert reset mid-TX at bit 3 -> TxData_o = 1 immediately and TxReady = 1 after release. The RX partial frame yields no RxValid. Back-to-back TX of 0x12 and 0x34 gives a 1-clock idle gap between frames.
